// File: rtl/instr_encode_loader.sv
// Packs instruction fields into 32-bit words and streams them into instruction
// memory through a 2-entry FIFO, starting at BASE_ADDR, one session at a time.
module instr_encode_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [4:0]        in_reg_a,
  input  logic [4:0]        in_reg_b,
  input  logic [4:0]        in_reg_d,
  input  logic [12:0]       in_offset,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0]   CAPACITY = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fifo_q [2];
  logic [31:0]       fifo_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcount_q, wcount_d;
  logic [ADDR_W:0]   accepted_q, accepted_d;
  logic              overflow_q, overflow_d;

  logic [31:0] enc_word;
  logic        xfer, keep, push, pop;

  assign enc_word = {in_offset, in_reg_a, in_reg_b, in_reg_d, in_opcode};

  // Ready depends only on registered state, never on mem_gnt.
  assign in_ready = (state_q == S_LOAD) && (count_q != 2'd2);
  assign xfer     = in_valid && in_ready;
  assign keep     = xfer && (accepted_q != CAPACITY);
  assign push     = keep;
  assign pop      = (count_q != 2'd0) && mem_gnt;

  assign mem_we     = (count_q != 2'd0);
  assign mem_wdata  = mem_we ? fifo_q[rd_ptr_q] : 32'd0;
  assign mem_addr   = addr_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign overflow   = overflow_q;
  assign word_count = wcount_q;

  always_comb begin
    state_d    = state_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wcount_d   = wcount_q;
    accepted_d = accepted_q;
    overflow_d = overflow_q;

    if (push) begin
      fifo_d[wr_ptr_q] = enc_word;
      wr_ptr_d         = ~wr_ptr_q;
      accepted_d       = accepted_q + (ADDR_W+1)'(1);
    end
    if (xfer && !keep) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      wcount_d = wcount_q + (ADDR_W+1)'(1);
      // Saturate at the top of memory so the address never wraps back to zero.
      if (addr_q != ADDR_TOP) begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          addr_d     = BASE;
          wcount_d   = '0;
          accepted_d = '0;
          overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (xfer && in_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_q == 2'd0) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      addr_q     <= BASE;
      wcount_q   <= '0;
      accepted_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wcount_q   <= wcount_d;
      accepted_q <= accepted_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/instr_encode_loader.md
INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 Parameter BASE_ADDR, default 0, first instruction-memory address written; SHALL be < 2^ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a load session; sampled only in IDLE.
REQ-006 in_valid  input  1  instruction fields valid.
REQ-007 in_ready  output  1  block can accept the fields this cycle.
REQ-008 in_opcode  input  4  opcode field.
REQ-009 in_reg_a  input  5  source register A.
REQ-010 in_reg_b  input  5  source register B.
REQ-011 in_reg_d  input  5  destination register.
REQ-012 in_offset  input  13  offset field.
REQ-013 in_last  input  1  qualifies the final instruction of the session.
REQ-014 mem_we  output  1  instruction-memory write request.
REQ-015 mem_addr  output  ADDR_W  write address.
REQ-016 mem_wdata  output  32  encoded instruction word.
REQ-017 mem_gnt  input  1  memory accepts the write this cycle.
REQ-018 busy  output  1  high in LOAD and DRAIN.
REQ-019 done  output  1  one-cycle pulse at session end.
REQ-020 overflow  output  1  sticky; instruction dropped for lack of memory space.
REQ-021 word_count  output  ADDR_W+1  words written to memory in the current/last session.

Function
REQ-022 Encoding: word[3:0]=opcode, [8:4]=reg_d, [13:9]=reg_b, [18:14]=reg_a, [31:19]=offset; no other bits, no sign extension.
REQ-023 States: IDLE, LOAD, DRAIN, DONE.
REQ-024 IDLE: in_ready=0; start=1 -> LOAD next cycle; mem_addr set to BASE_ADDR, word_count and overflow cleared on the same edge.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 Handshake: transfer occurs on edge where in_valid&&in_ready; fields need only be stable in that cycle.
REQ-027 Encoded words pass through a 2-entry FIFO; in_ready = (state==LOAD) && FIFO entries < 2; no combinational path from mem_gnt to in_ready.
REQ-028 Latency: word accepted at edge N into an empty FIFO SHALL appear on mem_wdata with mem_we=1 from cycle after edge N.
REQ-029 mem_we = FIFO not empty; mem_wdata = FIFO head; mem_addr, mem_wdata, mem_we SHALL hold stable while mem_we=1 and mem_gnt=0.
REQ-030 Write completes on edge with mem_we&&mem_gnt: FIFO pops, mem_addr and word_count increment by 1.
REQ-031 Simultaneous push and pop SHALL be supported; FIFO occupancy unchanged.
REQ-032 Capacity C = 2^ADDR_W - BASE_ADDR; once C words accepted in a session, further accepted transfers SHALL be dropped (handshake still completes) and overflow set; mem_addr never wraps.
REQ-033 Transfer with in_last=1 (kept or dropped) -> DRAIN next cycle; in_ready=0 in DRAIN.
REQ-034 DRAIN -> DONE when FIFO empty; DONE asserts done for exactly one cycle, then IDLE.
REQ-035 word_count and overflow SHALL hold their values in IDLE until next start.
REQ-036 in_valid=0 indefinitely in LOAD SHALL keep the block in LOAD with no writes beyond FIFO contents.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, FIFO empty, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, overflow=0, word_count=0.
REQ-038 Reset mid-session SHALL discard pending words; no mem_we after reset release until a new session writes.

Verification
REQ-039 start, one transfer opcode=4'h3, reg_d=1, reg_b=2, reg_a=3, offset=13'h1FFF, last=1, mem_gnt=1 -> mem_wdata=32'hFFF8C413 at addr 0, word_count=1, done pulse.
REQ-040 Four back-to-back transfers, mem_gnt=0 for 5 cycles -> in_ready drops after 2 accepts, addr/data stable; after gnt=1 addrs 0..3 in order, word_count=4.
REQ-041 ADDR_W=2, BASE_ADDR=2, five transfers, last on 5th -> only first 2 written (addr 2,3), overflow=1, word_count=2, done pulses.
REQ-042 rst_n low during DRAIN with 2 FIFO entries -> mem_we=0 immediately, IDLE; later start writes from BASE_ADDR.
REQ-043 start asserted during LOAD and in DONE -> no state change, counters unaffected.
